// File: rtl/click_pipeline_2phase_sync.sv
// Clocked chain of DEPTH two-phase bundled-data click stages acting as a small FIFO.
// A stage fires when its upstream phase differs from its own and it is currently empty.
module click_pipeline_2phase_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_req,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [DEPTH-1:0] p;
  logic [DEPTH-1:0] u;
  logic [DEPTH-1:0] n;
  logic [DEPTH-1:0] stage_full;
  logic [DEPTH-1:0] fire;
  logic [DEPTH:0]   up_ext;
  logic [DEPTH:0]   dn_ext;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] d_src [DEPTH];
  logic [CNT_W-1:0] count_c;

  // Extended phase vectors let DEPTH=1 fall out without special cases.
  assign up_ext     = {p, in_req};
  assign dn_ext     = {out_ack, p};
  assign u          = up_ext[DEPTH-1:0];
  assign n          = dn_ext[DEPTH:1];
  assign stage_full = p ^ n;
  assign fire       = (u ^ p) & ~stage_full;

  always_comb begin
    d_src[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      d_src[k] = d[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (fire[k]) begin
          p[k] <= ~p[k];
          d[k] <= d_src[k];
        end
      end
    end
  end

  always_comb begin
    count_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_c = count_c + CNT_W'(stage_full[k]);
    end
  end

  assign in_ack   = p[0];
  assign out_req  = p[DEPTH-1];
  assign out_data = d[DEPTH-1];
  assign count    = count_c;
  assign empty    = (count_c == '0);
  assign full     = (count_c == CNT_W'(DEPTH));

endmodule

// File: tb/tb_click_pipeline_2phase_sync.sv
// Bench for click_pipeline_2phase_sync: slot-occupancy reference model plus a token
// scoreboard for the DEPTH=3 instance, and a short directed run on a DEPTH=1 instance.
module tb_click_pipeline_2phase_sync;
  localparam int D = 3;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_req, out_ack, in_ack, out_req, empty, full;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   count;

  logic         in_req1, out_ack1, in_ack1, out_req1, empty1, full1;
  logic [15:0]  in_data1, out_data1;
  logic [0:0]   count1;

  click_pipeline_2phase_sync #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .count(count), .empty(empty), .full(full)
  );

  click_pipeline_2phase_sync #(.WIDTH(16), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_req(in_req1), .in_ack(in_ack1), .in_data(in_data1),
    .out_req(out_req1), .out_ack(out_ack1), .out_data(out_data1),
    .count(count1), .empty(empty1), .full(full1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each slot either holds a token or not; tokens advance one slot
  // per edge into an empty slot; the consumer removes the last slot's token.
  bit           occ [D];
  logic [W-1:0] val [D];
  bit           pend;
  bit           ack_m;
  bit           req_m;
  logic [W-1:0] din_m;
  logic [W-1:0] exp_q [$];
  int           cyc = 0;
  int           n_del = 0;
  int           last_del = 0;
  int           max_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int occ_count();
    int c = 0;
    for (int k = 0; k < D; k++) c += int'(occ[k]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < D; k++) begin
      occ[k] = 1'b0;
      val[k] = '0;
    end
    pend  = 1'b0;
    ack_m = 1'b0;
    req_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit mv   [D];
    bit nocc [D];
    bit src;
    for (int k = 0; k < D; k++) begin
      if (k == 0) src = pend;
      else        src = occ[k-1];
      mv[k] = src && !occ[k];
    end
    for (int k = D - 1; k >= 0; k--) begin
      nocc[k] = occ[k] || mv[k];
      if (k < D - 1 && mv[k+1]) nocc[k] = mv[k];
      if (mv[k]) begin
        if (k == 0) val[k] = din_m;
        else        val[k] = val[k-1];
      end
    end
    for (int k = 0; k < D; k++) occ[k] = nocc[k];
    if (mv[0]) begin
      pend  = 1'b0;
      ack_m = ~ack_m;
    end
    if (mv[D-1]) begin
      req_m = ~req_m;
      if (n_del >= 1 && cyc - last_del > max_gap) max_gap = cyc - last_del;
      last_del = cyc;
      n_del++;
    end
  endtask

  task automatic check_outputs();
    int c;
    c = occ_count();
    check("in_ack", in_ack, ack_m);
    check("out_req", out_req, req_m);
    check("out_data", out_data, val[D-1]);
    check("count", count, c);
    check("empty", empty, c == 0);
    check("full", full, c == D);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) model_reset();
    else       model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic offer(input logic [W-1:0] v);
    in_data = v;
    din_m   = v;
    in_req  = ~in_req;
    pend    = 1'b1;
    exp_q.push_back(v);
  endtask

  task automatic consume();
    if (exp_q.size() == 0) begin
      check("order_empty_q", 32'd1, 32'd0);
    end else begin
      check("order", out_data, exp_q.pop_front());
    end
    out_ack    = ~out_ack;
    occ[D-1]   = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_req  = 1'b0;
    out_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (occ_count() != 0 || pend); i++) begin
      if (occ[D-1]) consume();
      tick();
    end
    check("drained", occ_count(), 0);
  endtask

  initial begin
    int nxt;
    reset    = 1'b1;
    in_req   = 1'b0;
    out_ack  = 1'b0;
    in_data  = '0;
    in_req1  = 1'b0;
    out_ack1 = 1'b0;
    in_data1 = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    check("rst_in_ack", in_ack, 0);
    check("rst_out_req", out_req, 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst1_full", full1, 0);
    reset = 1'b0;

    // DEPTH=1 instance
    in_data1 = 16'hBEEF;
    in_req1  = 1'b1;
    tick();
    check("d1_ack_beef", in_ack1, 1);
    check("d1_req_beef", out_req1, 1);
    check("d1_data_beef", out_data1, 16'hBEEF);
    check("d1_full_beef", full1, 1);
    tick();
    check("d1_full_hold", full1, 1);
    in_data1 = 16'h1234;
    in_req1  = 1'b0;
    tick();
    check("d1_blocked_ack", in_ack1, 1);
    check("d1_blocked_data", out_data1, 16'hBEEF);
    out_ack1 = 1'b1;
    #1;
    check("d1_count_after_ack", count1, 0);
    tick();
    check("d1_ack_1234", in_ack1, 0);
    check("d1_req_1234", out_req1, 0);
    check("d1_data_1234", out_data1, 16'h1234);
    check("d1_full_1234", full1, 1);
    out_ack1 = 1'b0;
    tick();
    check("d1_empty_end", empty1, 1);

    // single token latency
    offer(8'h5A);
    tick();
    check("tok_in_ack", in_ack, 1);
    check("tok_count1", count, 1);
    tick();
    check("tok_out_req_early", out_req, 0);
    tick();
    check("tok_out_req", out_req, 1);
    check("tok_out_data", out_data, 8'h5A);
    check("tok_count3", count, 1);
    consume();
    tick();
    check("tok_count_done", count, 0);

    // fill with frozen consumer
    do_reset();
    nxt = 1;
    for (int i = 0; i < 15; i++) begin
      if (!pend && nxt <= 4) begin
        offer(8'(nxt));
        nxt++;
      end
      tick();
    end
    check("fill_full", full, 1);
    check("fill_count", count, 3);
    check("fill_in_ack_stalled", in_ack, 1);
    consume();
    tick();
    tick();
    tick();
    check("fill_released", in_ack, 0);
    drain();

    // eager stream
    do_reset();
    nxt = 0;
    n_del = 0;
    max_gap = 0;
    for (int i = 0; i < 200 && n_del < 16; i++) begin
      if (!pend && nxt < 16) begin
        offer(8'(nxt));
        nxt++;
      end
      if (occ[D-1]) consume();
      tick();
    end
    check("stream_delivered", n_del, 16);
    check("stream_gap", max_gap, 2);
    drain();
    check("stream_q_empty", exp_q.size(), 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(1) == 1) offer(8'($urandom));
      if (occ[D-1] && $urandom_range(1) == 1) consume();
      tick();
    end
    drain();
    check("rand_q_empty", exp_q.size(), 0);

    // reset while holding two tokens
    do_reset();
    offer(8'h11);
    for (int i = 0; i < 20 && occ_count() != 2; i++) begin
      if (!pend) offer(8'h22);
      tick();
    end
    check("mid_pre_count", count, 2);
    reset   = 1'b1;
    in_req  = 1'b0;
    out_ack = 1'b0;
    tick();
    check("mid_count", count, 0);
    check("mid_out_req", out_req, 0);
    check("mid_in_ack", in_ack, 0);
    reset = 1'b0;
    offer(8'hC3);
    tick();
    check("mid_tok_ack", in_ack, 1);
    tick();
    tick();
    check("mid_tok_req", out_req, 1);
    check("mid_tok_data", out_data, 8'hC3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1);
  end

endmodule
